// File: rtl/ahb_apb_pkg.sv
// Shared codes, FSM state type and byte-strobe helper for the AHB-Lite to APB3 bridge.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  // Naturally aligned byte strobes for buses up to 64 bits; callers truncate to their lane count.
  function automatic logic [7:0] size_to_strb(input logic [2:0] hsize, input logic [2:0] addr_lo);
    logic [7:0] ones;
    logic [2:0] base;
    ones = 8'h00;
    base = 3'b000;
    case (hsize)
      HSIZE_BYTE:  begin ones = 8'h01; base = addr_lo;                end
      HSIZE_HALF:  begin ones = 8'h03; base = {addr_lo[2:1], 1'b0};   end
      HSIZE_WORD:  begin ones = 8'h0F; base = {addr_lo[2], 2'b00};    end
      HSIZE_DWORD: begin ones = 8'hFF; base = 3'b000;                 end
      default:     begin ones = 8'h00; base = 3'b000;                 end
    endcase
    return ones << base;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_mp_resp_mux.sv
// Selects the addressed slave's PRDATA/PREADY/PSLVERR; reports not-ready when no slave is selected.
module apb_resp_mux #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 4
) (
  input  logic [SEL_W-1:0]             idx_i,
  input  logic                         active_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]        pready_i,
  input  logic [NUM_SLAVES-1:0]        pslverr_i,
  output logic [DATA_W-1:0]            prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o
);

  logic [NUM_SLAVES-1:0] hit;
  logic [DATA_W-1:0]     masked [NUM_SLAVES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign hit[gi]    = active_i && (idx_i == SEL_W'(gi));
      assign masked[gi] = prdata_i[gi*DATA_W +: DATA_W] & {DATA_W{hit[gi]}};
    end
  endgenerate

  // AND-OR mux: at most one hit bit is set, so OR-ing the masked lanes selects it.
  always_comb begin
    prdata_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      prdata_o = prdata_o | masked[i];
    end
    pready_o  = |(hit & pready_i);
    pslverr_o = |(hit & pslverr_i);
  end

endmodule

// File: rtl/ahb_apb_bridge_mp.sv
// Parametrised AHB-Lite to APB3 bridge with strobes, decode errors and a PREADY timeout.
module ahb_apb_bridge_mp
  import ahb_apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_LSB     = 16,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                         hclk_i,
  input  logic                         hreset_i,
  input  logic                         hsel_i,
  input  logic [ADDR_W-1:0]            haddr_i,
  input  logic [1:0]                   htrans_i,
  input  logic                         hwrite_i,
  input  logic [2:0]                   hsize_i,
  input  logic [DATA_W-1:0]            hwdata_i,
  input  logic                         hready_i,
  output logic                         hreadyout_o,
  output logic [1:0]                   hresp_o,
  output logic [DATA_W-1:0]            hrdata_o,
  output logic [ADDR_W-1:0]            paddr_o,
  output logic [NUM_SLAVES-1:0]        psel_o,
  output logic                         penable_o,
  output logic                         pwrite_o,
  output logic [DATA_W-1:0]            pwdata_o,
  output logic [DATA_W/8-1:0]          pstrb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]        pready_i,
  input  logic [NUM_SLAVES-1:0]        pslverr_i
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [SEL_W:0] NUM_SLAVES_EXT = (SEL_W + 1)'(NUM_SLAVES);

  bridge_state_e         state_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [DATA_W-1:0]     hrdata_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [SEL_W-1:0]      idx_q;
  logic [CNT_W-1:0]      wait_cnt_q;

  logic [SEL_W-1:0]      req_idx;
  logic                  accept;
  logic                  decode_err;
  logic                  timeout_hit;
  logic [STRB_W-1:0]     req_strb;
  logic [NUM_SLAVES-1:0] req_sel;
  logic [NUM_SLAVES-1:0] idx_sel;
  logic [DATA_W-1:0]     sel_prdata;
  logic                  sel_pready;
  logic                  sel_pslverr;

  // hreadyout_q is high exactly in IDLE, RESP and ERR2, the states that may take a new transfer.
  assign req_idx     = haddr_i[SEL_LSB +: SEL_W];
  assign accept      = hsel_i & hready_i & hreadyout_q &
                       ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));
  assign decode_err  = ({1'b0, req_idx} >= NUM_SLAVES_EXT) | (hsize_i > 3'(SIZE_MAX));
  assign req_strb    = STRB_W'(size_to_strb(hsize_i, 3'(haddr_i[SIZE_MAX-1:0])));
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt_q == CNT_W'(TO_LAST));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign req_sel[gi] = (req_idx == SEL_W'(gi));
      assign idx_sel[gi] = (idx_q == SEL_W'(gi));
    end
  endgenerate

  apb_resp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_resp_mux (
    .idx_i     (idx_q),
    .active_i  (|psel_q),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  // Bridge FSM; every bus output is a register updated alongside the state transition.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          if (accept) begin
            hreadyout_q <= 1'b0;
            if (decode_err) begin
              state_q <= ST_ERR1;
              hresp_q <= HRESP_ERROR;
            end else begin
              hresp_q  <= HRESP_OKAY;
              idx_q    <= req_idx;
              paddr_q  <= haddr_i;
              pwrite_q <= hwrite_i;
              pstrb_q  <= hwrite_i ? req_strb : '0;
              if (hwrite_i) begin
                state_q <= ST_WLATCH;
              end else begin
                state_q <= ST_SETUP;
                psel_q  <= req_sel;
              end
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_WLATCH: begin
          pwdata_q <= hwdata_i;
          psel_q   <= idx_sel;
          state_q  <= ST_SETUP;
        end
        ST_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_pready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (sel_pslverr) begin
              state_q <= ST_ERR1;
              hresp_q <= HRESP_ERROR;
            end else begin
              state_q     <= ST_RESP;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
              if (!pwrite_q) hrdata_q <= sel_prdata;
            end
          end else if (timeout_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= ST_ERR1;
            hresp_q   <= HRESP_ERROR;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = hrdata_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Directed and randomized AHB transfers against a transaction-level model of the bridge.
module tb_ahb_apb_bridge_mp;
  import ahb_apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          hsel, hwrite, hready;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hreadyout;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] paddr;
  logic [NS-1:0] psel;
  logic          penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pready, pslverr;

  ahb_apb_bridge_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SLAVES(NS), .SEL_LSB(16), .SEL_W(4), .TIMEOUT_CYC(TO)
  ) dut (
    .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hready_i(hready),
    .hreadyout_o(hreadyout), .hresp_o(hresp), .hrdata_o(hrdata), .paddr_o(paddr),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // APB slave models: each slave stalls slv_wait ACCESS cycles; unselected slaves idle ready.
  int          slv_wait [NS];
  logic [31:0] slv_data [NS];
  logic        slv_err  [NS];
  int          acc_cnt = 0;

  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      pready[i]            = !(psel[i] && penable) || (acc_cnt >= slv_wait[i]);
      pslverr[i]           = slv_err[i];
      prdata[i*DW +: DW]   = slv_data[i];
    end
  end

  int          checks   = 0;
  int          failures = 0;
  int          n_xfer   = 0;
  logic [31:0] last_rd  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One AHB transfer issued in the current cycle; returns in its completion cycle (#1 after edge).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int wt, input logic serr,
                      input logic [31:0] rdata);
    int idx, bytes, exp_acc, exp_lat, k, acc_seen;
    bit dec_err, tmo, apb_err, exp_err, done;
    logic [3:0] exp_strb;
    logic [2:0] exp_psel;
    logic [1:0] prev_resp;
    logic [31:0] exp_rd;
    idx     = int'(addr[19:16]);
    bytes   = 1 << size;
    dec_err = (idx >= NS) || (bytes > DW / 8);
    for (int j = 0; j < NS; j++) begin
      slv_data[j] = $urandom;
      slv_err[j]  = 1'($urandom_range(0, 1));
      slv_wait[j] = 0;
    end
    if (!dec_err) begin
      slv_wait[idx] = wt;
      slv_data[idx] = rdata;
      slv_err[idx]  = serr;
    end
    tmo      = !dec_err && (wt >= TO);
    apb_err  = !dec_err && !tmo && serr;
    exp_err  = dec_err || tmo || apb_err;
    exp_acc  = dec_err ? 0 : (tmo ? TO : wt + 1);
    exp_lat  = dec_err ? 2 : (wr ? 2 : 1) + exp_acc + (exp_err ? 2 : 1);
    exp_strb = (wr && !dec_err) ? 4'(((1 << bytes) - 1) << ((int'(addr[1:0]) / bytes) * bytes)) : 4'h0;
    exp_psel = dec_err ? 3'b000 : 3'(1 << idx);
    exp_rd   = (wr || exp_err) ? last_rd : rdata;

    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = size; hready = 1'b1;
    @(posedge clk); #1;
    hsel   = 1'($urandom_range(0, 1));
    htrans = ($urandom_range(0, 1) == 0) ? HTRANS_IDLE : HTRANS_BUSY;
    haddr  = $urandom;
    hwdata = wdata;
    k = 1; acc_seen = 0; done = 0; prev_resp = 2'bxx;
    while (!done && k <= 40) begin
      if (hreadyout) begin
        done = 1;
      end else begin
        prev_resp = hresp;
        if (penable) begin
          acc_seen++;
          if (acc_seen == 1) begin
            check("psel", psel, exp_psel);
            check("paddr", paddr, addr);
            check("pwrite", pwrite, wr);
            check("pstrb", pstrb, exp_strb);
            if (wr) check("pwdata", pwdata, wdata);
          end
        end else if (acc_seen > 0) begin
          check("psel_drop", psel, 0);
        end
        if (dec_err) check("dec_no_psel", psel, 0);
        @(posedge clk); #1;
        hwdata = $urandom;
        k++;
      end
    end
    check("latency", k, exp_lat);
    check("access_cycles", acc_seen, exp_acc);
    check("hresp", hresp, exp_err ? HRESP_ERROR : HRESP_OKAY);
    check("stall_resp", prev_resp, exp_err ? HRESP_ERROR : HRESP_OKAY);
    check("psel_done", psel, 0);
    check("hrdata", hrdata, exp_rd);
    last_rd = exp_rd;
    htrans = HTRANS_IDLE;
    n_xfer++;
    $display("xfer %0d %s addr=%08h size=%0d wait=%0d serr=%0d lat=%0d hresp=%0d hrdata=%08h",
             n_xfer, wr ? "WR" : "RD", addr, size, wt, serr, k, hresp, hrdata);
  endtask

  // Idle or blocked address phases; none of them may start a transfer.
  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      case ($urandom_range(0, 3))
        0:       begin hsel = 1'b0; htrans = HTRANS_NONSEQ; hready = 1'b1; end
        1:       begin hsel = 1'b1; htrans = HTRANS_IDLE;   hready = 1'b1; end
        2:       begin hsel = 1'b1; htrans = HTRANS_BUSY;   hready = 1'b1; end
        default: begin hsel = 1'b1; htrans = HTRANS_NONSEQ; hready = 1'b0; end
      endcase
      haddr = $urandom;
      @(posedge clk); #1;
      check("gap_ready", hreadyout, 1);
      check("gap_resp", hresp, HRESP_OKAY);
      check("gap_penable", penable, 0);
    end
    hsel = 1'b0; htrans = HTRANS_IDLE; hready = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          slot, wt;
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hwdata = '0; hready = 1'b1;
    for (int j = 0; j < NS; j++) begin slv_wait[j] = 0; slv_data[j] = '0; slv_err[j] = 1'b0; end
    @(posedge clk); @(posedge clk); #1;
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed steps; consecutive calls are issued back-to-back in the completion cycle.
    xfer(32'h0000_0004, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    xfer(32'h0001_0008, 1'b0, HSIZE_WORD, 32'h0,         2, 1'b0, 32'h1234_5678);
    xfer(32'h0002_0003, 1'b1, HSIZE_BYTE, 32'hAB00_0000, 0, 1'b0, 32'h0);
    xfer(32'h0003_0000, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h0);
    xfer(32'h0002_0000, 1'b0, HSIZE_WORD, 32'h0,         1, 1'b1, 32'h5555_AAAA);
    xfer(32'h0000_0020, 1'b0, HSIZE_WORD, 32'h0,        20, 1'b0, 32'h0);
    xfer(32'h0001_0002, 1'b1, HSIZE_HALF, 32'h7777_0000, 1, 1'b0, 32'h0);
    xfer(32'h0001_0000, 1'b1, HSIZE_DWORD, 32'h1,        0, 1'b0, 32'h0);
    xfer(32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'hCAFE_0001);
    xfer(32'h0002_0014, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'hCAFE_0002);
    idle_gap(3);

    // Randomized transfers with occasional gaps, decode errors, slave errors and timeouts.
    for (int n = 0; n < 40; n++) begin
      slot = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 2) : $urandom_range(3, 15);
      sz   = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, 2)) : HSIZE_DWORD;
      a    = $urandom;
      a[19:16] = 4'(slot);
      if (sz <= HSIZE_WORD) a = a & ~((32'd1 << sz) - 32'd1);
      wt   = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 12) : $urandom_range(0, 3);
      xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, wt, ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    // Reset in the middle of an ACCESS phase must abort it immediately.
    slv_wait[0] = 5; slv_err[0] = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_0040; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    check("pre_rst_penable", penable, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_hreadyout", hreadyout, 1);
    check("mid_rst_paddr", paddr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    xfer(32'h0001_0004, 1'b0, HSIZE_WORD, 32'h0, 1, 1'b0, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
